data_mem_system: RTL and testbench
==================================

# data_mem_system

Parametrised data-memory subsystem that replaces the bare RAM on the processor's data port. It combines a RAM array of configurable width, depth and read latency with a small memory-mapped I/O window (GPIO output, free-running cycle counter, compare timer with sticky interrupt). The block sits between the processor's `wren`/`address_dmem`/`data`/`q_dmem` port and the board, alongside the instruction ROM and register file.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, word-address width.
- `DATA_WIDTH`, 32, word width.
- `DEPTH`, 3840, RAM words; must satisfy `DEPTH <= MMIO_BASE`.
- `READ_LATENCY`, 1, cycles from read issue to `q_valid`; legal range 1..3.
- `MMIO_BASE`, 12'hF00, first word address of the MMIO window.
- `GPIO_WIDTH`, 8, GPIO output width.
- `MEMFILE`, "", optional RAM init file (`$readmemb`); empty means no init.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request this cycle.
- `wren`  in  1  1 = write, 0 = read; qualified by `req`.
- `address_dmem`  in  ADDR_WIDTH  word address.
- `data`  in  DATA_WIDTH  write data.
- `q_dmem`  out  DATA_WIDTH  read data.
- `q_valid`  out  1  one-cycle pulse: `q_dmem` holds a new read result.
- `gpio_out`  out  GPIO_WIDTH  GPIO register value.
- `timer_irq`  out  1  sticky timer interrupt.

## Operation

- Decode: `address_dmem < MMIO_BASE` → RAM (addresses ≥ DEPTH read 0, writes ignored); otherwise MMIO offset = `address_dmem - MMIO_BASE`.
- MMIO map (word offsets): 0 GPIO (R/W, low GPIO_WIDTH bits, reads zero-extended); 1 CYCLE (R; any write clears to 0); 2 TIMER_CMP (R/W); 3 STATUS (R: bit0 = irq pending; write with bit0 = 1 clears it). Other offsets read 0, writes ignored.
- CYCLE increments every cycle, DATA_WIDTH bits, wraps to 0. A write clears it; the increment is suppressed that cycle.
- Interrupt: sets when CYCLE == TIMER_CMP and TIMER_CMP != 0. It is sticky until cleared via STATUS. If set and clear occur in the same cycle, set wins.
- Reads: `req && !wren` issues a read. Data is sampled at issue (RAM word or MMIO value in that cycle) and carried through a READ_LATENCY-deep valid/data pipeline. This gives uniform latency for RAM and MMIO.
- One request is accepted per cycle, fully pipelined; there is no back-pressure.
- Writes: `req && wren` commits at the issue edge and is visible to a read issued in the next cycle.
- `q_dmem` holds its last valid value between pulses.

## Timing

- Reset (async assert, sync-safe release): `q_dmem` = 0, `q_valid` = 0, `gpio_out` = 0, `timer_irq` = 0, CYCLE = 0, TIMER_CMP = 0, read pipeline emptied. RAM contents are not reset.
- Read issued at edge N → `q_valid` high for the cycle after edge N+READ_LATENCY−1, i.e. READ_LATENCY cycles after the issue cycle.
- Back-to-back reads at consecutive cycles → consecutive `q_valid` pulses, in order.
- Reset mid-operation: in-flight reads are dropped, and no `q_valid` appears after release until a new read is issued.
- `req` low: no state change except CYCLE and the interrupt logic.
- CYCLE read returns the pre-increment value of the issue cycle.

## Structure

- Package `data_mem_system_pkg`: MMIO offset constants (`MMIO_GPIO`, `MMIO_CYCLE`, `MMIO_CMP`, `MMIO_STATUS`) and the STATUS bit index.
- Sub-module `mmio_regs`: GPIO, CYCLE, TIMER_CMP, STATUS and the interrupt logic, with a combinational read mux.
- Top level: address decode, RAM array, read-latency pipeline.

## Test plan

- Reset, then write 0xDEADBEEF to address 0x010, then read 0x010 next cycle with READ_LATENCY=2 → `q_valid` pulses 2 cycles after the read is issued, with `q_dmem` = 0xDEADBEEF.
- Back-to-back reads of 0x000, 0x001, 0x002 (preloaded 1, 2, 3) at latency 3 → three consecutive `q_valid` pulses carrying 1, 2, 3.
- Write 0xA5 to GPIO → `gpio_out` = 0xA5 after the edge. Then read offset 0 → 0x000000A5. Then read offset 7 → 0.
- Write TIMER_CMP = 20, then clear CYCLE → `timer_irq` rises when CYCLE reaches 20 and stays high. Write STATUS bit0 = 1 → `timer_irq` = 0. Clear coinciding with a match → `timer_irq` stays 1.
- Issue a read, then assert `reset` low before `q_valid` → `q_valid` never pulses, and all outputs are 0 during reset.
- Read address ≥ DEPTH below MMIO_BASE → 0. A write there followed by a read → still 0.

Source files
------------

// File: rtl/data_mem_system_pkg.sv
// Shared constants for the data-memory subsystem: MMIO register offsets and STATUS bit layout.
package data_mem_system_pkg;

   localparam int unsigned MMIO_GPIO   = 0;
   localparam int unsigned MMIO_CYCLE  = 1;
   localparam int unsigned MMIO_CMP    = 2;
   localparam int unsigned MMIO_STATUS = 3;

   localparam int unsigned STATUS_IRQ_BIT = 0;

endpackage

// File: rtl/data_mem_system_mmio_regs.sv
// MMIO register bank: GPIO output, free-running cycle counter, compare timer and
// sticky interrupt, with a combinational read mux indexed by word offset.
module mmio_regs
   import data_mem_system_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned GPIO_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] off,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  timer_irq
);

   logic [DATA_WIDTH-1:0] cycle;
   logic [DATA_WIDTH-1:0] cmp;
   logic                  sel_gpio, sel_cycle, sel_cmp, sel_status;
   logic                  irq_set, irq_clr;

   always_comb begin
      sel_gpio   = (off == ADDR_WIDTH'(MMIO_GPIO));
      sel_cycle  = (off == ADDR_WIDTH'(MMIO_CYCLE));
      sel_cmp    = (off == ADDR_WIDTH'(MMIO_CMP));
      sel_status = (off == ADDR_WIDTH'(MMIO_STATUS));
      irq_set    = (cycle == cmp) && (cmp != '0);
      irq_clr    = we && sel_status && wdata[STATUS_IRQ_BIT];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gpio_out <= '0;
         cmp      <= '0;
      end else if (we) begin
         if (sel_gpio) gpio_out <= wdata[GPIO_WIDTH-1:0];
         if (sel_cmp)  cmp      <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cycle <= '0;
      else if (we && sel_cycle) cycle <= '0;
      else cycle <= cycle + DATA_WIDTH'(1);
   end

   // Set takes priority so a match in the clearing cycle is never lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) timer_irq <= 1'b0;
      else if (irq_set) timer_irq <= 1'b1;
      else if (irq_clr) timer_irq <= 1'b0;
   end

   always_comb begin
      rdata = '0;
      if (sel_gpio)   rdata = DATA_WIDTH'(gpio_out);
      if (sel_cycle)  rdata = cycle;
      if (sel_cmp)    rdata = cmp;
      if (sel_status) rdata[STATUS_IRQ_BIT] = timer_irq;
   end

endmodule

// File: rtl/data_mem_system.sv
// Data-memory subsystem: RAM plus MMIO window behind one request port, with a
// fixed-latency read pipeline shared by RAM and MMIO reads.
module data_mem_system
  import data_mem_system_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 3840,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MMIO_BASE    = 12'hF00,
  parameter int unsigned GPIO_WIDTH   = 8,
  parameter              MEMFILE      = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] address_dmem,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q_dmem,
  output logic                  q_valid,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic [31:0]           addr_ext;
  logic                  is_ram, ram_hit;
  logic                  rd_issue, wr_issue, mmio_we;
  logic [RAM_AW-1:0]     ram_idx;
  logic [ADDR_WIDTH-1:0] mmio_off;
  logic [DATA_WIDTH-1:0] mmio_rdata, rd_data;

  logic [READ_LATENCY-1:0] vpipe;
  logic [DATA_WIDTH-1:0]   dpipe [READ_LATENCY];

  always_comb begin
    addr_ext = 32'(address_dmem);
    is_ram   = addr_ext < MMIO_BASE;
    ram_hit  = is_ram && (addr_ext < DEPTH);
    ram_idx  = address_dmem[RAM_AW-1:0];
    mmio_off = address_dmem - ADDR_WIDTH'(MMIO_BASE);
    rd_issue = req && !wren;
    wr_issue = req && wren;
    mmio_we  = wr_issue && !is_ram;
    rd_data  = '0;
    if (ram_hit) rd_data = ram[ram_idx];
    else if (!is_ram) rd_data = mmio_rdata;
  end

  always_ff @(posedge clock) begin
    if (wr_issue && ram_hit) ram[ram_idx] <= data;
  end

  mmio_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .GPIO_WIDTH (GPIO_WIDTH)
  ) u_mmio (
    .clock     (clock),
    .reset     (reset),
    .we        (mmio_we),
    .off       (mmio_off),
    .wdata     (data),
    .rdata     (mmio_rdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  // Each data stage only loads behind a valid, so the last stage holds the
  // most recent result between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_issue;
      if (rd_issue) dpipe[0] <= rd_data;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign q_valid = vpipe[READ_LATENCY-1];
  assign q_dmem  = dpipe[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_system.sv
// Scoreboard bench: two instances (read latency 2 and 3) share one stimulus stream.
module tb_data_mem_system;

   localparam int unsigned    DEPTH = 1024;
   localparam logic [11:0]    BASE  = 12'hF00;

   typedef struct packed {
      int          due;
      logic [31:0] val;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        req, wren;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic [31:0] q2, q3;
   logic        v2, v3;
   logic [7:0]  gpio2, gpio3;
   logic        irq2, irq3;

   int checks = 0;
   int errors = 0;
   int ecount = 0;
   int pulses = 0;

   exp_t sb2[$];
   exp_t sb3[$];

   logic [31:0] mdl_ram [int];
   logic [7:0]  mdl_gpio;

   always #5 clock = ~clock;
   always @(posedge clock) ecount <= ecount + 1;

   data_mem_system #(
      .DEPTH        (DEPTH),
      .READ_LATENCY (2)
   ) dut (
      .clock (clock), .reset (reset), .req (req), .wren (wren),
      .address_dmem (address_dmem), .data (data),
      .q_dmem (q2), .q_valid (v2), .gpio_out (gpio2), .timer_irq (irq2)
   );

   data_mem_system #(
      .DEPTH        (DEPTH),
      .READ_LATENCY (3)
   ) dut3 (
      .clock (clock), .reset (reset), .req (req), .wren (wren),
      .address_dmem (address_dmem), .data (data),
      .q_dmem (q3), .q_valid (v3), .gpio_out (gpio3), .timer_irq (irq3)
   );

   always @(negedge clock) begin
      exp_t e;
      if (v2) begin
         pulses++;
         checks++;
         if (sb2.size() == 0) begin
            errors++;
            $display("FAIL lat2_unexpected_valid q_dmem=%h edge=%0d", q2, ecount);
         end else begin
            e = sb2.pop_front();
            if (q2 !== e.val || ecount != e.due) begin
               errors++;
               $display("FAIL lat2_read got=%h@%0d exp=%h@%0d", q2, ecount, e.val, e.due);
            end
         end
      end
      if (v3) begin
         pulses++;
         checks++;
         if (sb3.size() == 0) begin
            errors++;
            $display("FAIL lat3_unexpected_valid q_dmem=%h edge=%0d", q3, ecount);
         end else begin
            e = sb3.pop_front();
            if (q3 !== e.val || ecount != e.due) begin
               errors++;
               $display("FAIL lat3_read got=%h@%0d exp=%h@%0d", q3, ecount, e.val, e.due);
            end
         end
      end
   end

   function automatic logic [31:0] model_read(input logic [11:0] a);
      if (a < BASE) begin
         if (a < DEPTH && mdl_ram.exists(int'(a))) return mdl_ram[int'(a)];
         return 32'h0;
      end
      if (a == BASE) return {24'h0, mdl_gpio};
      return 32'h0;
   endfunction

   task automatic do_write(input logic [11:0] a, input logic [31:0] d);
      if (a < BASE && a < DEPTH) mdl_ram[int'(a)] = d;
      if (a == BASE) mdl_gpio = d[7:0];
      req = 1'b1; wren = 1'b1; address_dmem = a; data = d;
      @(negedge clock);
      req = 1'b0; wren = 1'b0;
   endtask

   task automatic do_read(input logic [11:0] a, input logic [31:0] expv);
      sb2.push_back('{due: ecount + 2, val: expv});
      sb3.push_back('{due: ecount + 3, val: expv});
      req = 1'b1; wren = 1'b0; address_dmem = a; data = $urandom;
      @(negedge clock);
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b0; req = 1'b0; wren = 1'b0; address_dmem = '0; data = '0;
      mdl_gpio = '0;
      idle(2);
      checks++;
      if ({q2, v2, gpio2, irq2, q3, v3, gpio3, irq3} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got q=%h v=%b gpio=%h irq=%b exp all zero", q2, v2, gpio2, irq2);
      end
      reset = 1'b1;
      idle(1);
   endtask

   task automatic test_write_read;
      do_write(12'h010, 32'hDEADBEEF);
      do_read(12'h010, model_read(12'h010));
      idle(5);
      checks++;
      if (q2 !== 32'hDEADBEEF || v2 !== 1'b0) begin
         errors++;
         $display("FAIL q_dmem_hold got=%h v=%b exp=deadbeef v=0", q2, v2);
      end
   endtask

   task automatic test_back_to_back;
      do_write(12'h000, 32'd1);
      do_write(12'h001, 32'd2);
      do_write(12'h002, 32'd3);
      do_read(12'h000, 32'd1);
      do_read(12'h001, 32'd2);
      do_read(12'h002, 32'd3);
      do_read(12'h010, model_read(12'h010));
      idle(5);
   endtask

   task automatic test_gpio;
      do_write(BASE, 32'h000000A5);
      checks++;
      if (gpio2 !== 8'hA5) begin
         errors++;
         $display("FAIL gpio_write got=%h exp=a5", gpio2);
      end
      do_read(BASE, 32'h000000A5);
      do_read(BASE + 12'd7, 32'h0);
      do_write(BASE + 12'd7, 32'hFFFFFFFF);
      do_write(BASE, 32'h0000015A);
      checks++;
      if (gpio2 !== 8'h5A) begin
         errors++;
         $display("FAIL gpio_truncate got=%h exp=5a", gpio2);
      end
      do_read(BASE, model_read(BASE));
      do_read(BASE + 12'd7, 32'h0);
      idle(5);
   endtask

   task automatic test_out_of_range;
      do_read(12'h500, 32'h0);
      do_write(12'h500, 32'h12345678);
      do_read(12'h500, 32'h0);
      do_write(12'h3FF, 32'hCAFEF00D);
      do_read(12'h3FF, 32'hCAFEF00D);
      do_write(12'hEFF, 32'h0BADC0DE);
      do_read(12'hEFF, 32'h0);
      idle(5);
   endtask

   task automatic test_timer_irq;
      int a_edge, b_edge;
      a_edge = ecount + 1;
      do_write(BASE + 12'd1, 32'h0);
      idle(3);
      do_read(BASE + 12'd1, 32'd3);
      do_write(BASE + 12'd2, 32'd20);
      do_read(BASE + 12'd2, 32'd20);
      while (ecount < a_edge + 20) @(negedge clock);
      checks++;
      if (irq2 !== 1'b0) begin
         errors++;
         $display("FAIL irq_before_match got=%b exp=0", irq2);
      end
      idle(1);
      checks++;
      if (irq2 !== 1'b1) begin
         errors++;
         $display("FAIL irq_on_match got=%b exp=1", irq2);
      end
      idle(4);
      checks++;
      if (irq2 !== 1'b1 || irq3 !== 1'b1) begin
         errors++;
         $display("FAIL irq_sticky got=%b/%b exp=1/1", irq2, irq3);
      end
      do_read(BASE + 12'd3, 32'd1);
      do_write(BASE + 12'd3, 32'h0);
      checks++;
      if (irq2 !== 1'b1) begin
         errors++;
         $display("FAIL irq_clear_bit0_zero got=%b exp=1", irq2);
      end
      do_write(BASE + 12'd3, 32'h1);
      checks++;
      if (irq2 !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear got=%b exp=0", irq2);
      end
      do_read(BASE + 12'd3, 32'd0);
      b_edge = ecount + 1;
      do_write(BASE + 12'd1, 32'h0);
      while (ecount < b_edge + 20) @(negedge clock);
      checks++;
      if (irq2 !== 1'b0) begin
         errors++;
         $display("FAIL irq_before_coincide got=%b exp=0", irq2);
      end
      do_write(BASE + 12'd3, 32'h1);
      checks++;
      if (irq2 !== 1'b1) begin
         errors++;
         $display("FAIL irq_set_wins got=%b exp=1", irq2);
      end
      idle(5);
   endtask

   task automatic test_reset_mid;
      do_read(12'h010, 32'hDEADBEEF);
      reset = 1'b0;
      #1;
      sb2.delete();
      sb3.delete();
      pulses = 0;
      mdl_gpio = '0;
      checks++;
      if ({q2, v2, gpio2, irq2, q3, v3, gpio3, irq3} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got q=%h v=%b gpio=%h irq=%b exp all zero", q2, v2, gpio2, irq2);
      end
      idle(2);
      reset = 1'b1;
      idle(6);
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_drop got=%0d pulses exp=0", pulses);
      end
      do_read(12'h010, 32'hDEADBEEF);
      do_read(BASE, 32'h0);
      idle(5);
   endtask

   task automatic test_drain;
      checks++;
      if (sb2.size() != 0 || sb3.size() != 0) begin
         errors++;
         $display("FAIL missing_valid got=%0d/%0d outstanding exp=0/0", sb2.size(), sb3.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_gpio();
      test_out_of_range();
      test_timer_irq();
      test_reset_mid();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
